double_dabble_seq: RTL

- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one shift per clock.
- Sits directly upstream of the nibble-select mux (8-bit in, sel, 4-bit out).
- Its packed tens:ones byte drives the mux's 8-bit input, and its hundreds digit goes to the display path separately.
- Converts one WIDTH-bit unsigned value per start request, with a busy/done handshake.

---
 rtl/double_dabble_seq_if.sv | 23 ++
 rtl/double_dabble_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/double_dabble_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives start/bin and the slave (converter) returns busy/done/bcd.
interface double_dabble_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [7:0]            bcd_lo;

    modport master (
        output start, bin,
        input  busy, done, bcd, bcd_lo
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, bcd_lo
    );
endinterface

// File: rtl/double_dabble_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
// A start taken in IDLE runs WIDTH adjust+shift iterations; the final scratch
// value lands in bcd together with a one-cycle done pulse.
module double_dabble_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    double_dabble_seq_if.slave dd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    // Too few digits for the largest operand would silently truncate results.
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_check
        $error("double_dabble_seq: DIGITS too small for WIDTH");
    end

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_sr_q, bin_sr_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [BW-1:0]    adjusted;

    // Next-state: accept in IDLE, otherwise adjust digits then shift once.
    always_comb begin
        state_d   = state_q;
        bin_sr_d  = bin_sr_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        adjusted  = scratch_q;
        case (state_q)
            IDLE: begin
                if (dd.start) begin
                    bin_sr_d  = dd.bin;
                    scratch_d = '0;
                    count_d   = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (scratch_q[4*i +: 4] >= 4'd5) begin
                        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
                    end
                end
                // The adjusted scratch's top bit always drops out: a digit
                // never exceeds 9 after the final shift, so nothing is lost.
                {scratch_d, bin_sr_d} = {adjusted[BW-2:0], bin_sr_q, 1'b0};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    bcd_d   = scratch_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; asynchronous clear aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_sr_q  <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_sr_q  <= bin_sr_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign dd.busy   = busy_q;
    assign dd.done   = done_q;
    assign dd.bcd    = bcd_q;
    assign dd.bcd_lo = bcd_q[7:0];

endmodule
